writeback_arbiter: RTL and testbench

- Write-side companion of the CPU register file. Merges single-cycle ALU results and variable-latency load returns into that file's single write port (wd_reg/wdv/wren).
- Load returns are buffered in a small FIFO.
- Keeps a 32-bit pending-destination scoreboard that issue logic uses for RAW/WAW stalls.
- Sits between execute/memory and the register file.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/writeback_arbiter.sv | 111 +++++++++++
 tb/tb_writeback_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer: strict-order FIFO of writeback entries.
// Pointers wrap modulo Depth; the occupancy count separates full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [AW:0] count_o
);

  wb_entry_t       mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is dropped; a pop of an empty one is ignored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy next state
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and buffered load returns onto the single register-file
// write port, and tracks outstanding destinations for issue stalls.
module writeback_arbiter #(
  // Must match wb_pkg::XLEN, which sizes the buffered entries.
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic [31:0]     busy,
  output logic [4:0]      wd_reg,
  output logic [XLEN-1:0] wdv,
  output logic            wren
);

  import wb_pkg::*;

  localparam int unsigned LdCntW = $clog2(LD_DEPTH) + 1;

  wb_entry_t          alu_entry, ld_entry, fifo_head, sel_entry;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [LdCntW-1:0]  fifo_count;
  logic               sel_alu, sel_ld, write_d;

  logic               wren_q, wren_d;
  logic [4:0]         wd_reg_q, wd_reg_d;
  logic [XLEN-1:0]    wdv_q, wdv_d;
  logic [31:0]        busy_q, busy_d;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign ld_entry  = '{rd: ld_rd, data: ld_data};

  wb_fifo #(
    .Depth (LD_DEPTH)
  ) u_ld_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ld_valid),
    .push_data_i (ld_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // A full buffer must drain, so it takes the port and back-pressures the ALU.
  assign alu_ready = !fifo_full;
  assign ld_ready  = !fifo_full;
  assign sel_alu   = alu_valid && !fifo_full;
  assign sel_ld    = !fifo_empty && (fifo_full || !alu_valid);
  assign fifo_pop  = sel_ld;
  assign sel_entry = sel_alu ? alu_entry : fifo_head;

  // Writes to x0 are consumed but never reach the register file.
  assign write_d   = (sel_alu || sel_ld) && (sel_entry.rd != '0);

  assign iss_ready = !busy_q[iss_rd];

  // Next write-port values and scoreboard update
  always_comb begin
    wren_d   = write_d;
    wd_reg_d = write_d ? sel_entry.rd : wd_reg_q;
    wdv_d    = write_d ? sel_entry.data : wdv_q;
    busy_d   = busy_q;
    if (write_d) begin
      busy_d[sel_entry.rd] = 1'b0;
    end
    // Set after clear so a same-register collision leaves the bit set.
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q   <= 1'b0;
      wd_reg_q <= '0;
      wdv_q    <= '0;
      busy_q   <= '0;
    end else begin
      wren_q   <= wren_d;
      wd_reg_q <= wd_reg_d;
      wdv_q    <= wdv_d;
      busy_q   <= busy_d;
    end
  end

  assign wren   = wren_q;
  assign wd_reg = wd_reg_q;
  assign wdv    = wdv_q;
  assign busy   = busy_q;

  // Full flag and occupancy must never disagree.
  a_full_count : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == LdCntW'(LD_DEPTH)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter with a queue-based model
// and a scoreboard monitor on the register-file write port.
module tb_writeback_arbiter;
  import wb_pkg::*;

  localparam int unsigned LD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, iss_rd = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, iss_ready, wren;
  logic [31:0] busy, wdv;
  logic [4:0]  wd_reg;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .XLEN     (32),
    .LD_DEPTH (LD_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .busy      (busy),
    .wd_reg    (wd_reg),
    .wdv       (wdv),
    .wren      (wren)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  wb_entry_t   mq[$];
  logic [31:0] busy_m = '0;
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;

  // Pending requests; a source holds its request until it is accepted.
  logic        a_v = 1'b0, l_v = 1'b0, i_v = 1'b0;
  logic [4:0]  a_rd = '0, l_rd = '0, i_rd = '0;
  logic [31:0] a_d = '0, l_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // One clock of stimulus; the model advances by the arbitration rules.
  task automatic drive();
    bit        full, empty, take_alu, take_ld, iss_ok, ld_acc;
    wb_entry_t sel;
    @(negedge clk);
    alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
    ld_valid  = l_v; ld_rd  = l_rd; ld_data  = l_d;
    iss_valid = i_v; iss_rd = i_rd;
    #1;
    full  = (mq.size() == LD_DEPTH);
    empty = (mq.size() == 0);
    chk("alu_ready", alu_ready, !full);
    chk("ld_ready", ld_ready, !full);
    chk("busy", busy, busy_m);
    if (i_v) chk("iss_ready", iss_ready, !busy_m[i_rd]);
    iss_ok   = i_v && !busy_m[i_rd];
    take_alu = a_v && !full;
    take_ld  = !empty && (full || !a_v);
    sel      = '0;
    if (take_alu) sel = '{rd: a_rd, data: a_d};
    else if (take_ld) sel = mq[0];
    if ((take_alu || take_ld) && sel.rd != 0) begin
      exp_q.push_back('{rd: sel.rd, data: sel.data, cyc: cyc + 1});
      busy_m[sel.rd] = 1'b0;
    end
    if (take_ld) void'(mq.pop_front());
    ld_acc = l_v && !full;
    if (ld_acc) mq.push_back('{rd: l_rd, data: l_d});
    if (iss_ok && i_rd != 0) busy_m[i_rd] = 1'b1;
    if (take_alu) a_v = 1'b0;
    if (ld_acc) l_v = 1'b0;
    i_v = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive();
  endtask

  // Scoreboard monitor: every write must match the next expected one, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && wren) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got rd %0d data %0h, expected no write (cycle %0d)",
                   wd_reg, wdv, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_rd", wd_reg, e.rd);
          chk("write_data", wdv, e.data);
          chk("write_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk("rst_wren", wren, 0);
    chk("rst_wd_reg", wd_reg, 0);
    chk("rst_wdv", wdv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Single ALU write with scoreboard round trip
    i_v = 1; i_rd = 5'd3;
    drive();
    a_v = 1; a_rd = 5'd3; a_d = 32'hDEADBEEF;
    i_v = 1; i_rd = 5'd3;
    drive();
    chk("busy3_set", busy[3], 1);
    drive();
    chk("busy3_clear", busy[3], 0);

    // ALU priority over loads, then loads retire in order
    a_v = 1; a_rd = 5'd7; a_d = 32'h70; l_v = 1; l_rd = 5'd5; l_d = 32'h11;
    drive();
    a_v = 1; a_rd = 5'd7; a_d = 32'h71; l_v = 1; l_rd = 5'd6; l_d = 32'h22;
    drive();
    a_v = 1; a_rd = 5'd7; a_d = 32'h72;
    drive();
    idle(4);

    // FIFO full: five loads pushed against a continuously valid ALU
    for (int k = 0; k < 5; k++) begin
      l_v = 1; l_rd = 5'(9 + k); l_d = 32'h100 + k;
      for (int t = 0; t < 8 && l_v; t++) begin
        if (!a_v) begin a_v = 1; a_rd = 5'd8; a_d = $urandom; end
        drive();
      end
      chk("ld_accept_bound", l_v, 0);
    end
    idle(10);

    // x0 destinations are consumed silently
    a_v = 1; a_rd = 5'd0; a_d = 32'h55;
    l_v = 1; l_rd = 5'd0; l_d = 32'h66;
    i_v = 1; i_rd = 5'd0;
    drive();
    idle(4);
    chk("rd0_busy", busy, 0);

    // Randomized traffic with held requests
    for (int k = 0; k < 1500; k++) begin
      if (!a_v && $urandom_range(1, 0) == 1) begin
        a_v = 1; a_rd = 5'($urandom_range(31, 0)); a_d = $urandom;
      end
      if (!l_v && $urandom_range(2, 0) == 0) begin
        l_v = 1; l_rd = 5'($urandom_range(31, 0)); l_d = $urandom;
      end
      if ($urandom_range(2, 0) == 0) begin
        i_v = 1; i_rd = 5'($urandom_range(31, 0));
      end
      drive();
    end
    idle(12);

    // Async reset with queued loads and pending scoreboard bits
    busy_m = busy_m;
    for (int r = 5; r <= 7; r++) begin
      i_v = 1; i_rd = 5'(r);
      drive();
    end
    for (int k = 0; k < 3; k++) begin
      l_v = 1; l_rd = 5'(5 + k); l_d = 32'h200 + k;
      for (int t = 0; t < 4 && l_v; t++) begin
        if (!a_v) begin a_v = 1; a_rd = 5'd8; a_d = $urandom; end
        drive();
      end
    end
    @(posedge clk);
    #2;
    chk("pre_reset_busy", busy & 32'h000000E0, 32'h000000E0);
    rst_n = 1'b0;
    #1;
    chk("arst_wren", wren, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ld_ready", ld_ready, 1);
    chk("arst_alu_ready", alu_ready, 1);
    exp_q.delete();
    mq.delete();
    busy_m = '0;
    a_v = 0; l_v = 0; i_v = 0;
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Everything predicted must have been written
    @(posedge clk);
    #2;
    chk("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
